maquina_bebidas_param: RTL and testbench

Parametrised successor of the fixed-menu coffee machine controller: a coin-operated beverage dispenser with a configurable number of drinks, ingredients, prices and dispense-step duration. It adds change return, cancel and coin rejection. It sits between the front-panel buttons and coin acceptor on one side, and the ingredient valve drivers and the credit/change display logic on the other.

---
 rtl/maquina_bebidas_param.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_maquina_bebidas_param.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/maquina_bebidas_param.sv
// Coin-operated beverage dispenser controller with configurable menu.
// Accepts C/Q coins up to a credit ceiling, dispenses the lowest-index
// selected drink by opening each recipe valve for T_STEP cycles (plus an
// optional sugar phase), and returns change on completion or on cancel.
// Ports:
//   clk_50Mhz, rst (async, active-low)
//   C, Q          coin acceptor levels (rising edge = one coin)
//   sel           drink buttons, rising edge per bit
//   azucar_req    sugar option, sampled when a drink starts
//   cancel        rising edge requests a refund
//   ing, azucar   valve enables
//   bebidaLista   drink-complete pulse
//   credito       current credit
//   cambio        last change amount, cambio_valido pulses on update
//   rechazo       coin-rejected pulse
//   err_credito   insufficient-credit pulse
module maquina_bebidas_param #(
  parameter int unsigned N_BEB      = 5,
  parameter int unsigned N_ING      = 4,
  parameter int unsigned CREDIT_W   = 12,
  parameter int unsigned COIN_C     = 100,
  parameter int unsigned COIN_Q     = 500,
  parameter int unsigned MAX_CREDIT = 2000,
  parameter logic [N_BEB*CREDIT_W-1:0] PRECIOS =
    {12'd1500, 12'd1000, 12'd800, 12'd600, 12'd300},
  parameter logic [N_BEB*N_ING-1:0] RECETAS =
    {4'b1111, 4'b1011, 4'b0101, 4'b0011, 4'b0001},
  parameter int unsigned T_STEP     = 50
) (
  input  logic                clk_50Mhz,
  input  logic                rst,
  input  logic                C,
  input  logic                Q,
  input  logic [N_BEB-1:0]    sel,
  input  logic                azucar_req,
  input  logic                cancel,
  output logic [N_ING-1:0]    ing,
  output logic                azucar,
  output logic                bebidaLista,
  output logic [CREDIT_W-1:0] credito,
  output logic [CREDIT_W-1:0] cambio,
  output logic                cambio_valido,
  output logic                rechazo,
  output logic                err_credito
);

  localparam int unsigned IDX_W  = (N_BEB > 1)  ? $clog2(N_BEB)  : 1;
  localparam int unsigned STEP_W = (N_ING > 1)  ? $clog2(N_ING)  : 1;
  localparam int unsigned TMR_W  = (T_STEP > 1) ? $clog2(T_STEP) : 1;
  localparam int unsigned SUM_W  = CREDIT_W + 1;

  typedef enum logic [1:0] {IDLE, DISPENSE, SUGAR, DONE} state_t;

  state_t              state, state_d;
  logic                c_prev, q_prev, cancel_prev;
  logic [N_BEB-1:0]    sel_prev;
  logic [IDX_W-1:0]    beb_idx, beb_idx_d;
  logic                sugar_lat, sugar_lat_d;
  logic [STEP_W-1:0]   step, step_d;
  logic [TMR_W-1:0]    timer, timer_d;

  logic [N_ING-1:0]    ing_d;
  logic                azucar_d, bebida_d, cambio_valido_d, rechazo_d, err_d;
  logic [CREDIT_W-1:0] credito_d, cambio_d;

  // Per-drink price and recipe lookup tables
  logic [CREDIT_W-1:0] price  [N_BEB];
  logic [N_ING-1:0]    recipe [N_BEB];

  always_comb begin
    for (int i = 0; i < int'(N_BEB); i++) begin
      price[i]  = PRECIOS[i*CREDIT_W +: CREDIT_W];
      recipe[i] = RECETAS[i*N_ING +: N_ING];
    end
  end

  logic             c_rise, q_rise, cancel_rise, coin_any;
  logic [N_BEB-1:0] sel_rise;

  assign c_rise      = C & ~c_prev;
  assign q_rise      = Q & ~q_prev;
  assign cancel_rise = cancel & ~cancel_prev;
  assign sel_rise    = sel & ~sel_prev;
  assign coin_any    = c_rise | q_rise;

  // Lowest-index rising selection and the first valve of its recipe
  logic              sel_hit;
  logic [IDX_W-1:0]  sel_idx;
  logic [N_ING-1:0]  sel_recipe;
  logic [STEP_W-1:0] first_bit;

  always_comb begin
    sel_hit = 1'b0;
    sel_idx = '0;
    for (int i = int'(N_BEB) - 1; i >= 0; i--) begin
      if (sel_rise[i]) begin
        sel_hit = 1'b1;
        sel_idx = IDX_W'(i);
      end
    end
    sel_recipe = recipe[sel_idx];
    first_bit  = '0;
    for (int i = int'(N_ING) - 1; i >= 0; i--) begin
      if (sel_recipe[i]) first_bit = STEP_W'(i);
    end
  end

  // Next set recipe bit above the current step
  logic [N_ING-1:0]  cur_recipe;
  logic [STEP_W-1:0] next_bit;
  logic              next_found;

  always_comb begin
    cur_recipe = recipe[beb_idx];
    next_bit   = '0;
    next_found = 1'b0;
    for (int i = 0; i < int'(N_ING); i++) begin
      if (!next_found && cur_recipe[i] && (i > int'(step))) begin
        next_found = 1'b1;
        next_bit   = STEP_W'(i);
      end
    end
  end

  // Coin accumulation: C before Q, each checked against the ceiling
  // in one extra bit so the sum cannot wrap
  logic [SUM_W-1:0]    acc, trial_c, trial_q;
  logic                coin_rej;
  logic [CREDIT_W-1:0] coin_credit;

  always_comb begin
    acc      = {1'b0, credito};
    coin_rej = 1'b0;
    trial_c  = acc + SUM_W'(COIN_C);
    if (c_rise) begin
      if (trial_c <= SUM_W'(MAX_CREDIT)) acc = trial_c;
      else                               coin_rej = 1'b1;
    end
    trial_q = acc + SUM_W'(COIN_Q);
    if (q_rise) begin
      if (trial_q <= SUM_W'(MAX_CREDIT)) acc = trial_q;
      else                               coin_rej = 1'b1;
    end
    coin_credit = acc[CREDIT_W-1:0];
  end

  logic timer_end, finish;
  assign timer_end = (timer == TMR_W'(T_STEP - 1));

  // Next-state and next-output logic
  always_comb begin
    state_d         = state;
    beb_idx_d       = beb_idx;
    sugar_lat_d     = sugar_lat;
    step_d          = step;
    timer_d         = timer;
    ing_d           = ing;
    azucar_d        = azucar;
    credito_d       = credito;
    cambio_d        = cambio;
    bebida_d        = 1'b0;
    cambio_valido_d = 1'b0;
    rechazo_d       = 1'b0;
    err_d           = 1'b0;
    finish          = 1'b0;

    case (state)
      IDLE: begin
        ing_d    = '0;
        azucar_d = 1'b0;
        // A selection or an effective cancel consumes the cycle; any
        // coin edge arriving with it is rejected.
        if (sel_hit) begin
          rechazo_d = coin_any;
          if (credito >= price[sel_idx]) begin
            state_d     = DISPENSE;
            beb_idx_d   = sel_idx;
            sugar_lat_d = azucar_req;
            step_d      = first_bit;
            timer_d     = '0;
            ing_d       = N_ING'(1) << first_bit;
          end else begin
            err_d = 1'b1;
          end
        end else if (cancel_rise && (credito != '0)) begin
          rechazo_d       = coin_any;
          cambio_d        = credito;
          cambio_valido_d = 1'b1;
          credito_d       = '0;
        end else begin
          credito_d = coin_credit;
          rechazo_d = coin_rej;
        end
      end

      DISPENSE: begin
        rechazo_d = coin_any;
        if (timer_end) begin
          timer_d = '0;
          if (next_found) begin
            step_d = next_bit;
            ing_d  = N_ING'(1) << next_bit;
          end else if (sugar_lat) begin
            state_d  = SUGAR;
            ing_d    = '0;
            azucar_d = 1'b1;
          end else begin
            finish = 1'b1;
          end
        end else begin
          timer_d = timer + TMR_W'(1);
        end
      end

      SUGAR: begin
        rechazo_d = coin_any;
        if (timer_end) begin
          timer_d = '0;
          finish  = 1'b1;
        end else begin
          timer_d = timer + TMR_W'(1);
        end
      end

      DONE: begin
        rechazo_d = coin_any;
        state_d   = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // Drink complete: report change (possibly zero) and clear credit
    if (finish) begin
      state_d         = DONE;
      ing_d           = '0;
      azucar_d        = 1'b0;
      bebida_d        = 1'b1;
      cambio_d        = credito - price[beb_idx];
      cambio_valido_d = 1'b1;
      credito_d       = '0;
    end
  end

  // State, edge-history and output registers
  always_ff @(posedge clk_50Mhz or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      c_prev        <= 1'b0;
      q_prev        <= 1'b0;
      cancel_prev   <= 1'b0;
      sel_prev      <= '0;
      beb_idx       <= '0;
      sugar_lat     <= 1'b0;
      step          <= '0;
      timer         <= '0;
      ing           <= '0;
      azucar        <= 1'b0;
      bebidaLista   <= 1'b0;
      credito       <= '0;
      cambio        <= '0;
      cambio_valido <= 1'b0;
      rechazo       <= 1'b0;
      err_credito   <= 1'b0;
    end else begin
      state         <= state_d;
      c_prev        <= C;
      q_prev        <= Q;
      cancel_prev   <= cancel;
      sel_prev      <= sel;
      beb_idx       <= beb_idx_d;
      sugar_lat     <= sugar_lat_d;
      step          <= step_d;
      timer         <= timer_d;
      ing           <= ing_d;
      azucar        <= azucar_d;
      bebidaLista   <= bebida_d;
      credito       <= credito_d;
      cambio        <= cambio_d;
      cambio_valido <= cambio_valido_d;
      rechazo       <= rechazo_d;
      err_credito   <= err_d;
    end
  end

endmodule

// File: tb/tb_maquina_bebidas_param.sv
// Self-checking bench for maquina_bebidas_param: directed scenarios plus a
// randomized sequence of coins, purchases and cancels against a
// transaction-level credit/change model with per-cycle valve schedules.
module tb_maquina_bebidas_param;

  localparam int unsigned N_BEB    = 5;
  localparam int unsigned N_ING    = 4;
  localparam int unsigned CREDIT_W = 12;
  localparam int unsigned T_STEP   = 50;
  localparam int COIN_C     = 100;
  localparam int COIN_Q     = 500;
  localparam int MAX_CREDIT = 2000;
  localparam logic [N_BEB*CREDIT_W-1:0] PRECIOS =
    {12'd1500, 12'd1000, 12'd800, 12'd600, 12'd300};
  localparam logic [N_BEB*N_ING-1:0] RECETAS =
    {4'b1111, 4'b1011, 4'b0101, 4'b0011, 4'b0001};

  int price_tab  [N_BEB] = '{300, 600, 800, 1000, 1500};
  int recipe_tab [N_BEB] = '{1, 3, 5, 11, 15};

  logic                clk = 1'b0;
  logic                rst;
  logic                c, q, azucar_req, cancel;
  logic [N_BEB-1:0]    sel;
  logic [N_ING-1:0]    ing;
  logic                azucar, bebida_lista, cambio_valido, rechazo, err_credito;
  logic [CREDIT_W-1:0] credito, cambio;

  int checks = 0;
  int errors = 0;
  int m_credit = 0;
  int m_cambio = 0;

  maquina_bebidas_param #(
    .N_BEB(N_BEB), .N_ING(N_ING), .CREDIT_W(CREDIT_W),
    .COIN_C(COIN_C), .COIN_Q(COIN_Q), .MAX_CREDIT(MAX_CREDIT),
    .PRECIOS(PRECIOS), .RECETAS(RECETAS), .T_STEP(T_STEP)
  ) dut (
    .clk_50Mhz(clk), .rst(rst), .C(c), .Q(q), .sel(sel),
    .azucar_req(azucar_req), .cancel(cancel), .ing(ing), .azucar(azucar),
    .bebidaLista(bebida_lista), .credito(credito), .cambio(cambio),
    .cambio_valido(cambio_valido), .rechazo(rechazo), .err_credito(err_credito)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic coin(input bit dc, input bit dq);
    bit exp_rej;
    exp_rej = 1'b0;
    if (dc) begin
      if (m_credit + COIN_C <= MAX_CREDIT) m_credit += COIN_C; else exp_rej = 1'b1;
    end
    if (dq) begin
      if (m_credit + COIN_Q <= MAX_CREDIT) m_credit += COIN_Q; else exp_rej = 1'b1;
    end
    c = dc; q = dq;
    tick();
    check("coin_credito", 32'(credito), m_credit);
    check("coin_rechazo", 32'(rechazo), 32'(exp_rej));
    c = 1'b0; q = 1'b0;
    tick();
    check("coin_rechazo_clear", 32'(rechazo), 0);
    check("coin_credito_hold", 32'(credito), m_credit);
  endtask

  task automatic do_cancel();
    bit refund;
    refund = (m_credit > 0);
    if (refund) begin
      m_cambio = m_credit;
      m_credit = 0;
    end
    cancel = 1'b1;
    tick();
    check("cancel_cambio", 32'(cambio), m_cambio);
    check("cancel_valido", 32'(cambio_valido), 32'(refund));
    check("cancel_credito", 32'(credito), m_credit);
    cancel = 1'b0;
    tick();
    check("cancel_valido_clear", 32'(cambio_valido), 0);
  endtask

  task automatic buy(input logic [N_BEB-1:0] mask, input bit sug, input bit disturb);
    int d;
    int price;
    int exp_ing[$];
    int exp_az[$];
    d = 0;
    for (int i = int'(N_BEB) - 1; i >= 0; i--) if (mask[i]) d = i;
    price = price_tab[d];
    sel = mask; azucar_req = sug;
    tick();
    sel = '0; azucar_req = 1'b0;
    if (m_credit < price) begin
      check("err_credito_pulse", 32'(err_credito), 1);
      check("err_ing_closed", 32'(ing), 0);
      check("err_credito_kept", 32'(credito), m_credit);
      tick();
      check("err_credito_clear", 32'(err_credito), 0);
      check("err_ing_still_closed", 32'(ing), 0);
      return;
    end
    check("buy_no_err", 32'(err_credito), 0);
    for (int b = 0; b < int'(N_ING); b++) begin
      if (((recipe_tab[d] >> b) & 1) == 1) begin
        for (int t = 0; t < int'(T_STEP); t++) begin
          exp_ing.push_back(1 << b);
          exp_az.push_back(0);
        end
      end
    end
    if (sug) begin
      for (int t = 0; t < int'(T_STEP); t++) begin
        exp_ing.push_back(0);
        exp_az.push_back(1);
      end
    end
    for (int k = 0; k < exp_ing.size(); k++) begin
      check("disp_ing", 32'(ing), exp_ing[k]);
      check("disp_azucar", 32'(azucar), exp_az[k]);
      check("disp_not_done", 32'(bebida_lista), 0);
      check("disp_credito", 32'(credito), m_credit);
      check("disp_rechazo", 32'(rechazo), (disturb && k == 6) ? 1 : 0);
      check("disp_no_change", 32'(cambio_valido), 0);
      if (disturb) begin
        if (k == 5)  c = 1'b1;
        if (k == 6)  c = 1'b0;
        if (k == 10) begin sel = '1; cancel = 1'b1; end
        if (k == 11) begin sel = '0; cancel = 1'b0; end
      end
      tick();
    end
    m_cambio = m_credit - price;
    m_credit = 0;
    check("done_bebida", 32'(bebida_lista), 1);
    check("done_valido", 32'(cambio_valido), 1);
    check("done_cambio", 32'(cambio), m_cambio);
    check("done_credito", 32'(credito), 0);
    check("done_ing", 32'(ing), 0);
    check("done_azucar", 32'(azucar), 0);
    tick();
    check("done_bebida_clear", 32'(bebida_lista), 0);
    check("done_valido_clear", 32'(cambio_valido), 0);
    check("done_cambio_held", 32'(cambio), m_cambio);
  endtask

  initial begin
    rst = 1'b0; c = 1'b0; q = 1'b0; cancel = 1'b0; azucar_req = 1'b0; sel = '0;
    tick(); tick();
    check("rst_credito", 32'(credito), 0);
    check("rst_cambio", 32'(cambio), 0);
    check("rst_ing", 32'(ing), 0);
    check("rst_pulses", {27'd0, azucar, bebida_lista, cambio_valido, rechazo, err_credito}, 0);
    rst = 1'b1;
    tick();

    // C then Q, then refund
    coin(1, 0);
    coin(0, 1);
    do_cancel();
    do_cancel();

    // Asynchronous reset in the middle of a drink
    coin(0, 1); coin(1, 0);
    sel = 5'b00010;
    tick();
    sel = '0;
    repeat (3) tick();
    check("pre_rst_ing", 32'(ing), 1);
    check("pre_rst_cambio", 32'(cambio), 600);
    #3 rst = 1'b0;
    #1;
    check("async_rst_ing", 32'(ing), 0);
    check("async_rst_credito", 32'(credito), 0);
    check("async_rst_cambio", 32'(cambio), 0);
    check("async_rst_azucar", 32'(azucar), 0);
    #2 rst = 1'b1;
    m_credit = 0; m_cambio = 0;
    tick();

    // Drink 1 with 700 credit, no sugar
    coin(0, 1); coin(1, 0); coin(1, 0);
    buy(5'b00010, 1'b0, 1'b0);
    // Drink 1 with sugar, exact credit, disturbances during dispense
    coin(0, 1); coin(1, 0);
    buy(5'b00010, 1'b1, 1'b1);
    // Insufficient credit then refund
    coin(1, 0);
    buy(5'b00010, 1'b0, 1'b0);
    do_cancel();
    // Ceiling: 1600 + Q rejected, simultaneous C+Q, exact 2000 accepted
    coin(0, 1); coin(0, 1); coin(0, 1); coin(1, 0);
    coin(0, 1);
    coin(1, 1);
    coin(1, 0); coin(1, 0); coin(1, 0);
    coin(1, 0);
    check("ceiling_credito", 32'(credito), 2000);
    // Two buttons together: lowest index wins
    buy(5'b00110, 1'b0, 1'b1);

    // Randomized sequence
    for (int it = 0; it < 40; it++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 4)       coin(1, 0);
      else if (r < 6)  coin(0, 1);
      else if (r == 6) coin(1, 1);
      else if (r < 9)  buy(N_BEB'($urandom_range(1, 31)), 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 1)));
      else             do_cancel();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
